// File: rtl/sd_card_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_card_cmd_responder
// Purpose  : Card-side SD CMD line endpoint. Receives 48-bit host command
//            frames, validates them, presents index/argument to the card
//            logic, then returns a 48-bit R1-style response NCR clocks later.
// Config   : SD_CMD_CRC_CHECK_EN - when defined, a CRC7 mismatch on a received
//            frame drops the frame and pulses frame_error. When undefined the
//            received CRC7 field is ignored. Response CRC7 is always generated.
// Revision : 1.0 - initial release
// ============================================================================
module sd_card_cmd_responder #(
  parameter int NCR = 2  // idle clocks between CHECK and response start bit, 2..64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_in,
  input  logic [31:0] resp_status,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        frame_error,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX    = 3'd1,
    S_CHECK = 3'd2,
    S_WAIT  = 3'd3,
    S_TX    = 3'd4
  } state_t;

  // WAIT counts down from NCR-1 to 0, so it lasts exactly NCR clocks.
  localparam logic [5:0] C_WAIT_LOAD = 6'(NCR - 1);

  // One serial step of the CRC7 LFSR, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;     // RX/TX bit index, WAIT countdown
  logic [38:0] rx_sr_q, rx_sr_d;         // received bits 46..8 (dir, index, arg)
  logic [6:0]  crc_q, crc_d;             // running CRC7 for RX and TX
  logic [39:0] resp_q, resp_d;           // response bits 46..8, MSB goes out first
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_error_q, frame_error_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        cmd_out_q, cmd_out_d;
  logic        cmd_oe_q, cmd_oe_d;

  logic        w_crc_ok;
  logic        w_frame_ok;
  logic [5:0]  w_tx_next;

`ifdef SD_CMD_CRC_CHECK_EN
  logic [6:0]  rx_crc_q, rx_crc_d;       // received CRC7 field, bits 7..1
  assign w_crc_ok = (crc_q == rx_crc_q);
`else
  assign w_crc_ok = 1'b1;
`endif

  // Evaluated on the clock that samples the end bit: rx_sr/crc hold bits 47..1.
  assign w_frame_ok = rx_sr_q[38] & cmd_in & w_crc_ok;
  assign w_tx_next  = bit_cnt_q - 6'd1;

  // Next-state and datapath logic for the receive / wait / transmit sequence.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    crc_d         = crc_q;
    resp_d        = resp_q;
    cmd_valid_d   = 1'b0;
    frame_error_d = 1'b0;
    cmd_index_d   = cmd_index_q;
    cmd_arg_d     = cmd_arg_q;
    cmd_out_d     = cmd_out_q;
    cmd_oe_d      = cmd_oe_q;
`ifdef SD_CMD_CRC_CHECK_EN
    rx_crc_d      = rx_crc_q;
`endif

    case (state_q)
      S_IDLE: begin
        cmd_out_d = 1'b1;
        cmd_oe_d  = 1'b0;
        if (!cmd_in) begin
          // Start bit (bit 47, always 0) is folded into the CRC here.
          state_d   = S_RX;
          bit_cnt_d = 6'd46;
          rx_sr_d   = '0;
          crc_d     = crc7_step(7'd0, 1'b0);
        end
      end

      S_RX: begin
        if (bit_cnt_q >= 6'd8) begin
          rx_sr_d = {rx_sr_q[37:0], cmd_in};
          crc_d   = crc7_step(crc_q, cmd_in);
        end
`ifdef SD_CMD_CRC_CHECK_EN
        if ((bit_cnt_q < 6'd8) && (bit_cnt_q != 6'd0)) begin
          rx_crc_d = {rx_crc_q[5:0], cmd_in};
        end
`endif
        if (bit_cnt_q == 6'd0) begin
          state_d = S_CHECK;
          if (w_frame_ok) begin
            cmd_valid_d = 1'b1;
            cmd_index_d = rx_sr_q[37:32];
            cmd_arg_d   = rx_sr_q[31:0];
          end else begin
            frame_error_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      S_CHECK: begin
        // CMD0 gets no response; bad frames were already flagged.
        if (cmd_valid_q && (cmd_index_q != 6'd0)) begin
          state_d   = S_WAIT;
          bit_cnt_d = C_WAIT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (bit_cnt_q == 6'd0) begin
          // Last WAIT clock: latch status and put the start bit on the line.
          state_d   = S_TX;
          bit_cnt_d = 6'd47;
          cmd_out_d = 1'b0;
          cmd_oe_d  = 1'b1;
          resp_d    = {1'b0, cmd_index_q, resp_status, 1'b0};
          crc_d     = crc7_step(7'd0, 1'b0);
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      S_TX: begin
        if (bit_cnt_q == 6'd0) begin
          state_d   = S_IDLE;
          cmd_out_d = 1'b1;
          cmd_oe_d  = 1'b0;
        end else begin
          bit_cnt_d = w_tx_next;
          if (w_tx_next >= 6'd8) begin
            cmd_out_d = resp_q[39];
            resp_d    = {resp_q[38:0], 1'b0};
            crc_d     = crc7_step(crc_q, resp_q[39]);
          end else if (w_tx_next != 6'd0) begin
            cmd_out_d = crc_q[6];
            crc_d     = {crc_q[5:0], 1'b0};
          end else begin
            cmd_out_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the line and clears everything.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      crc_q         <= '0;
      resp_q        <= '0;
      cmd_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      cmd_index_q   <= '0;
      cmd_arg_q     <= '0;
      cmd_out_q     <= 1'b1;
      cmd_oe_q      <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
      rx_crc_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      crc_q         <= crc_d;
      resp_q        <= resp_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_error_q <= frame_error_d;
      cmd_index_q   <= cmd_index_d;
      cmd_arg_q     <= cmd_arg_d;
      cmd_out_q     <= cmd_out_d;
      cmd_oe_q      <= cmd_oe_d;
`ifdef SD_CMD_CRC_CHECK_EN
      rx_crc_q      <= rx_crc_d;
`endif
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign frame_error = frame_error_q;
  assign cmd_index   = cmd_index_q;
  assign cmd_arg     = cmd_arg_q;
  assign cmd_out     = cmd_out_q;
  assign cmd_oe      = cmd_oe_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
